fetch_arb_wbi: RTL and testbench

Round-robin scheduler sharing the single weight/bias/input fetch engine (256-bit BRAM read port plus fetch counter) among three requesters: W, B and I. It holds one tile read pointer per requester. For each granted request it issues one start pulse with that requester's base address, waits for the engine's done, returns a per-requester done pulse, and advances the pointer by one tile, wrapping within the requester's region. It sits between the tile controllers and the fetch engine.

---
 rtl/fetch_arb_wbi.sv | 223 ++++++++++++++++++++++
 tb/tb_fetch_arb_wbi.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arb_wbi.sv
// fetch_arb_wbi
// Round-robin scheduler that shares one weight/bias/input fetch engine
// among three requesters (bit0 = W, bit1 = B, bit2 = I). Each requester owns
// a tile read pointer that walks its own BRAM region one tile at a time and
// wraps back to the region base.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req[2:0]          level requests, held until the matching done bit
//   clear_ptrs        pulse: reload all pointers with their bases
//   grant[2:0]        one-hot engine owner, 0 when idle
//   done[2:0]         one-cycle completion pulse on the granted bit
//   wrapped[2:0]      one-cycle pulse with done when that pointer wrapped
//   fetch_start       one-cycle start pulse to the fetch engine
//   fetch_base        tile start address, valid while grant != 0
//   fetch_done        completion from the fetch engine
//   timeout_err       sticky watchdog error flag
//
// Build option: define FETCH_ARB_TIMEOUT_EN to enable the WAIT watchdog.
// Without it WAIT is unbounded and timeout_err is tied low.
module fetch_arb_wbi #(
   parameter int ADDR_WIDTH           = 11,
   parameter int NUM_FETCHES_PER_TILE = 32,
   parameter int W_BASE               = 0,
   parameter int W_DEPTH              = 64,
   parameter int B_BASE               = 64,
   parameter int B_DEPTH              = 32,
   parameter int I_BASE               = 112,
   parameter int I_DEPTH              = 384,
   parameter int TIMEOUT_CYCLES       = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   input  logic                  clear_ptrs,
   output logic [2:0]            grant,
   output logic [2:0]            done,
   output logic [2:0]            wrapped,
   output logic                  fetch_start,
   output logic [ADDR_WIDTH-1:0] fetch_base,
   input  logic                  fetch_done,
   output logic                  timeout_err
);

   typedef logic [ADDR_WIDTH:0]   wide_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   if ((W_DEPTH % NUM_FETCHES_PER_TILE) != 0 || (B_DEPTH % NUM_FETCHES_PER_TILE) != 0 ||
       (I_DEPTH % NUM_FETCHES_PER_TILE) != 0 || TIMEOUT_CYCLES < 1 ||
       (W_BASE + W_DEPTH) > (1 << ADDR_WIDTH) || (B_BASE + B_DEPTH) > (1 << ADDR_WIDTH) ||
       (I_BASE + I_DEPTH) > (1 << ADDR_WIDTH)) begin : g_cfg_err
      $error("fetch_arb_wbi: invalid region or timeout configuration");
   end

   function automatic addr_t base_of(input logic [1:0] idx);
      case (idx)
         2'd0:    base_of = addr_t'(W_BASE);
         2'd1:    base_of = addr_t'(B_BASE);
         default: base_of = addr_t'(I_BASE);
      endcase
   endfunction

   // Region end, one bit wider so base+depth == 2^ADDR_WIDTH is representable.
   function automatic wide_t limit_of(input logic [1:0] idx);
      case (idx)
         2'd0:    limit_of = wide_t'(W_BASE + W_DEPTH);
         2'd1:    limit_of = wide_t'(B_BASE + B_DEPTH);
         default: limit_of = wide_t'(I_BASE + I_DEPTH);
      endcase
   endfunction

   // First set request bit searching upward (cyclic) from last+1.
   function automatic logic [1:0] pick_idx(input logic [2:0] r, input logic [1:0] last);
      logic found;
      int   c;
      pick_idx = 2'd0;
      found    = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         c = (int'(last) + k) % 3;
         if (!found && r[c]) begin
            pick_idx = 2'(c);
            found    = 1'b1;
         end
      end
   endfunction

   function automatic logic [1:0] idx_of(input logic [2:0] onehot);
      if (onehot[1])      idx_of = 2'd1;
      else if (onehot[2]) idx_of = 2'd2;
      else                idx_of = 2'd0;
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  grant_q, grant_d;
   logic [1:0]  last_q, last_d;
   addr_t       fbase_q, fbase_d;
   addr_t       ptr_q [3];
   addr_t       ptr_d [3];
   logic [1:0]  pick;
   logic        err_q, err_d;

`ifdef FETCH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;   // current DONE was reached by timeout
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      fbase_d     = fbase_q;
      ptr_d       = ptr_q;
      err_d       = err_q;
      fetch_start = 1'b0;
      done        = 3'b000;
      wrapped     = 3'b000;
      pick        = pick_idx(req, last_q);
`ifdef FETCH_ARB_TIMEOUT_EN
      cnt_d       = '0;
      to_d        = 1'b0;
      if (clear_ptrs) err_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_d = 3'b001 << pick;
               // Latch the base so a clear_ptrs mid-fetch cannot move it.
               for (int i = 0; i < 3; i++)
                  if (pick == 2'(i)) fbase_d = ptr_q[i];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            fetch_start = 1'b1;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (fetch_done) begin
               state_d = ST_DONE;
            end
`ifdef FETCH_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_DONE;
               to_d    = 1'b1;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: begin // ST_DONE
            done    = grant_q;
            last_d  = idx_of(grant_q);
            grant_d = 3'b000;
            fbase_d = '0;
            state_d = ST_IDLE;
`ifdef FETCH_ARB_TIMEOUT_EN
            if (!to_q) begin
`else
            begin
`endif
               for (int i = 0; i < 3; i++) begin
                  if (grant_q[i]) begin
                     if (({1'b0, ptr_q[i]} + wide_t'(NUM_FETCHES_PER_TILE)) >= limit_of(2'(i))) begin
                        ptr_d[i]   = base_of(2'(i));
                        wrapped[i] = 1'b1;
                     end else begin
                        ptr_d[i] = ptr_q[i] + addr_t'(NUM_FETCHES_PER_TILE);
                     end
                  end
               end
            end
         end
      endcase

      // Reload wins over any advance in the same cycle.
      if (clear_ptrs) begin
         for (int i = 0; i < 3; i++) ptr_d[i] = base_of(2'(i));
         wrapped = 3'b000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 3'b000;
         last_q  <= 2'd2;
         fbase_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < 3; i++) ptr_q[i] <= base_of(2'(i));
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         fbase_q <= fbase_d;
         err_q   <= err_d;
         for (int i = 0; i < 3; i++) ptr_q[i] <= ptr_d[i];
      end
   end

`ifdef FETCH_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign grant      = grant_q;
   assign fetch_base = fbase_q;

endmodule

// File: tb/tb_fetch_arb_wbi.sv
module tb_fetch_arb_wbi;

`ifdef FETCH_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = 3'b000;
   logic        clear_ptrs = 1'b0;
   logic        fetch_done = 1'b0;
   logic [2:0]  grant, done, wrapped;
   logic        fetch_start, timeout_err;
   logic [10:0] fetch_base;

   fetch_arb_wbi #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .clear_ptrs(clear_ptrs),
      .grant(grant), .done(done), .wrapped(wrapped),
      .fetch_start(fetch_start), .fetch_base(fetch_base),
      .fetch_done(fetch_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] r;
      logic       c;
      logic       f;
      logic [2:0] g;
      logic [2:0] d;
      logic [2:0] w;
      logic       s;
      int         b;
   } vec_t;

   vec_t vq[$];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] r, input logic c, input logic f, input logic [2:0] g,
                      input logic [2:0] d, input logic [2:0] w, input logic s, input int b);
      vec_t v;
      v.r = r; v.c = c; v.f = f; v.g = g; v.d = d; v.w = w; v.s = s; v.b = b;
      vq.push_back(v);
   endtask

   // One minimum-latency tile: IDLE, ISSUE, WAIT(fetch_done), DONE.
   task automatic add_tile(input logic [2:0] r, input int idx, input int base,
                           input logic wr, input logic clr);
      logic [2:0] g;
      g = 3'b001 << idx;
      add(r, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 0);
      add(r, 1'b0, 1'b0, g, 3'b000, 3'b000, 1'b1, base);
      add(r, 1'b0, 1'b1, g, 3'b000, 3'b000, 1'b0, base);
      add(r, clr, 1'b0, g, g, wr ? g : 3'b000, 1'b0, base);
   endtask

   task automatic run_table(input string tag);
      foreach (vq[i]) begin
         req        = vq[i].r;
         clear_ptrs = vq[i].c;
         fetch_done = vq[i].f;
         @(negedge clk);
         chk($sformatf("%s row%0d grant", tag, i), int'(grant), int'(vq[i].g));
         chk($sformatf("%s row%0d done", tag, i), int'(done), int'(vq[i].d));
         chk($sformatf("%s row%0d wrapped", tag, i), int'(wrapped), int'(vq[i].w));
         chk($sformatf("%s row%0d fetch_start", tag, i), int'(fetch_start), int'(vq[i].s));
         chk($sformatf("%s row%0d fetch_base", tag, i), int'(fetch_base), vq[i].b);
         @(posedge clk); #1;
      end
      req = 3'b000; clear_ptrs = 1'b0; fetch_done = 1'b0;
      vq.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 3'b000; clear_ptrs = 1'b0; fetch_done = 1'b0;
      @(posedge clk); #1;
      chk("reset grant", int'(grant), 0);
      chk("reset done", int'(done), 0);
      chk("reset wrapped", int'(wrapped), 0);
      chk("reset fetch_start", int'(fetch_start), 0);
      chk("reset fetch_base", int'(fetch_base), 0);
      chk("reset timeout_err", int'(timeout_err), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_start(input string nm);
      bit found = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (fetch_start) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk({nm, " fetch_start seen"}, int'(found), 1);
   endtask

   int b2[6] = '{0, 64, 112, 32, 64, 144};
   int w2[6] = '{0, 1, 0, 1, 1, 0};
   int n;

   initial begin
      do_reset();

      // W tiles, ignored fetch_done, dropped req, clear at DONE, W-then-B order
      add_tile(3'b001, 0, 0, 1'b0, 1'b0);
      add_tile(3'b001, 0, 32, 1'b1, 1'b0);
      add(3'b000, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 0);   // IDLE, fetch_done ignored
      add(3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 0);
      add(3'b001, 1'b0, 1'b1, 3'b001, 3'b000, 3'b000, 1'b1, 0);   // ISSUE, fetch_done ignored
      add(3'b000, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 0);   // req dropped, still WAIT
      add(3'b000, 1'b0, 1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 0);
      add(3'b000, 1'b0, 1'b0, 3'b001, 3'b001, 3'b000, 1'b0, 0);
      add_tile(3'b010, 1, 64, 1'b0, 1'b1);                         // clear at DONE: no wrap pulse
      add_tile(3'b011, 0, 0, 1'b0, 1'b0);                          // W pointer back at base
      add_tile(3'b011, 1, 64, 1'b1, 1'b0);
      add(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 0);
      run_table("single");

      // All three requests held: W,B,I,W,B,I
      do_reset();
      for (int t = 0; t < 6; t++) add_tile(3'b111, t % 3, b2[t], w2[t][0], 1'b0);
      add(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 0);
      run_table("rr");

      // clear_ptrs with DONE of I at pointer 144
      do_reset();
      add_tile(3'b100, 2, 112, 1'b0, 1'b0);
      add_tile(3'b100, 2, 144, 1'b0, 1'b1);
      add_tile(3'b100, 2, 112, 1'b0, 1'b0);
      add(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 0);
      run_table("clr");

      // Long engine latency; clear_ptrs mid-WAIT must not move fetch_base
      req = 3'b010;
      wait_start("long");
      chk("long base", int'(fetch_base), 64);
      chk("long grant", int'(grant), 2);
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         clear_ptrs = (k == 2);
         @(negedge clk);
         chk($sformatf("long wait%0d base", k), int'(fetch_base), 64);
         chk($sformatf("long wait%0d done", k), int'(done), 0);
         chk($sformatf("long wait%0d grant", k), int'(grant), 2);
         @(posedge clk); #1;
         clear_ptrs = 1'b0;
      end
      fetch_done = 1'b1; req = 3'b000;
      @(posedge clk); #1;
      fetch_done = 1'b0;
      @(negedge clk);
      chk("long done", int'(done), 2);
      chk("long wrapped", int'(wrapped), 2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("long idle grant", int'(grant), 0);
      @(posedge clk); #1;

      // I pointer reloaded by the mid-WAIT clear; then reset in WAIT
      req = 3'b100;
      wait_start("after clear");
      chk("after clear base", int'(fetch_base), 112);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midreset grant", int'(grant), 0);
      chk("midreset fetch_base", int'(fetch_base), 0);
      chk("midreset done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1; req = 3'b111;
      @(posedge clk); #1;
      @(negedge clk);
      chk("postreset grant W first", int'(grant), 1);
      chk("postreset base", int'(fetch_base), 0);
      @(posedge clk); #1;
      req = 3'b000; fetch_done = 1'b1;
      @(posedge clk); #1;
      fetch_done = 1'b0;
      @(negedge clk);
      chk("postreset done", int'(done), 1);
      @(posedge clk); #1;

`ifdef FETCH_ARB_TIMEOUT_EN
      // Watchdog: no fetch_done at all
      req = 3'b100;
      wait_start("timeout");
      chk("timeout base", int'(fetch_base), 112);
      @(posedge clk); #1;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done != 3'b000) break;
         @(posedge clk); #1;
      end
      chk("timeout latency", n, 17);
      chk("timeout done", int'(done), 4);
      chk("timeout wrapped", int'(wrapped), 0);
      chk("timeout err set", int'(timeout_err), 1);
      req = 3'b000;
      @(posedge clk); #1;
      req = 3'b100;
      wait_start("timeout retry");
      chk("timeout ptr unchanged", int'(fetch_base), 112);
      chk("timeout err sticky", int'(timeout_err), 1);
      @(posedge clk); #1;
      fetch_done = 1'b1;
      @(posedge clk); #1;
      fetch_done = 1'b0; req = 3'b000;
      @(negedge clk);
      chk("timeout retry done", int'(done), 4);
      @(posedge clk); #1;
      clear_ptrs = 1'b1;
      @(posedge clk); #1;
      clear_ptrs = 1'b0;
      @(negedge clk);
      chk("timeout err cleared", int'(timeout_err), 0);
`else
      @(negedge clk);
      chk("timeout_err tied low", int'(timeout_err), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
